// File: rtl/boot_rom_arbiter.sv
// rtl/boot_rom_arbiter.sv - two-port boot ROM arbiter; define BOOT_ROM_ARB_RR_EN for round-robin, else fixed instr priority
module boot_rom_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int ROM_DEPTH  = 548
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  instr_req_i,
  input  logic [ADDR_WIDTH-1:0] instr_addr_i,
  output logic                  instr_gnt_o,
  output logic                  instr_rvalid_o,
  output logic [DATA_WIDTH-1:0] instr_rdata_o,
  output logic                  instr_err_o,
  input  logic                  data_req_i,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  output logic [DATA_WIDTH-1:0] data_rdata_o,
  output logic                  data_err_o,
  output logic                  rom_csn_o,
  output logic [ADDR_WIDTH-1:0] rom_a_o,
  input  logic [DATA_WIDTH-1:0] rom_q_i
);

  // One extra bit so a depth equal to 2**ADDR_WIDTH still compares correctly.
  localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(ROM_DEPTH);

  // Arbitration bookkeeping: 0 = instr granted last, 1 = data granted last.
  logic last_grant;

  logic instr_in_range;
  logic data_in_range;
  logic instr_wins;
  logic instr_gnt;
  logic data_gnt;
  logic rom_access;

  // Per-port response flags, each live for exactly the cycle after a grant.
  logic instr_rvalid_q;
  logic instr_err_q;
  logic data_rvalid_q;
  logic data_err_q;

  assign instr_in_range = ({1'b0, instr_addr_i} < DEPTH_LIM);
  assign data_in_range  = ({1'b0, data_addr_i}  < DEPTH_LIM);

`ifdef BOOT_ROM_ARB_RR_EN
  // Round-robin: on contention the port that did not win last time goes first.
  assign instr_wins = last_grant;
`else
  // Fixed priority: instruction fetch always wins contention.
  assign instr_wins = 1'b1;
  // last_grant is still tracked so both builds share identical state.
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  // Combinational grant in the request cycle; nothing is granted during reset.
  always_comb begin
    instr_gnt = 1'b0;
    data_gnt  = 1'b0;
    if (!RST) begin
      if (instr_req_i && data_req_i) begin
        instr_gnt = instr_wins;
        data_gnt  = !instr_wins;
      end else begin
        instr_gnt = instr_req_i;
        data_gnt  = data_req_i;
      end
    end
  end

  assign instr_gnt_o = instr_gnt;
  assign data_gnt_o  = data_gnt;

  // Only an in-range grant selects the ROM; out-of-range grants leave it idle.
  assign rom_access = (instr_gnt && instr_in_range) || (data_gnt && data_in_range);
  assign rom_csn_o  = !rom_access;

  // Drive the granted address on a real ROM access, zero otherwise.
  always_comb begin
    rom_a_o = '0;
    if (instr_gnt && instr_in_range) begin
      rom_a_o = instr_addr_i;
    end else if (data_gnt && data_in_range) begin
      rom_a_o = data_addr_i;
    end
  end

  // Response flags and arbitration pointer; reset favours instr first.
  always_ff @(posedge CLK) begin
    if (RST) begin
      instr_rvalid_q <= 1'b0;
      instr_err_q    <= 1'b0;
      data_rvalid_q  <= 1'b0;
      data_err_q     <= 1'b0;
      last_grant     <= 1'b1;
    end else begin
      instr_rvalid_q <= instr_gnt;
      instr_err_q    <= instr_gnt && !instr_in_range;
      data_rvalid_q  <= data_gnt;
      data_err_q     <= data_gnt && !data_in_range;
      if (instr_gnt) begin
        last_grant <= 1'b0;
      end else if (data_gnt) begin
        last_grant <= 1'b1;
      end
    end
  end

  // A reset arriving in the response cycle drops that response immediately.
  assign instr_rvalid_o = instr_rvalid_q && !RST;
  assign instr_err_o    = instr_err_q && !RST;
  assign data_rvalid_o  = data_rvalid_q && !RST;
  assign data_err_o     = data_err_q && !RST;

  // ROM data is only forwarded on a valid, in-range response.
  assign instr_rdata_o = (instr_rvalid_o && !instr_err_o) ? rom_q_i : '0;
  assign data_rdata_o  = (data_rvalid_o && !data_err_o) ? rom_q_i : '0;

endmodule

// File: tb/tb_boot_rom_arbiter.sv
// tb/tb_boot_rom_arbiter.sv - self-checking bench for boot_rom_arbiter
module tb_boot_rom_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        instr_req = 1'b0;
  logic [9:0]  instr_addr = '0;
  logic        instr_gnt;
  logic        instr_rvalid;
  logic [31:0] instr_rdata;
  logic        instr_err;
  logic        data_req = 1'b0;
  logic [9:0]  data_addr = '0;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        data_err;
  logic        rom_csn;
  logic [9:0]  rom_a;
  logic [31:0] rom_q;

  int tests = 0;
  int fails = 0;

  boot_rom_arbiter dut (
    .CLK(CLK), .RST(RST),
    .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(instr_gnt),
    .instr_rvalid_o(instr_rvalid), .instr_rdata_o(instr_rdata), .instr_err_o(instr_err),
    .data_req_i(data_req), .data_addr_i(data_addr), .data_gnt_o(data_gnt),
    .data_rvalid_o(data_rvalid), .data_rdata_o(data_rdata), .data_err_o(data_err),
    .rom_csn_o(rom_csn), .rom_a_o(rom_a), .rom_q_i(rom_q)
  );

  always #5 CLK = ~CLK;

  // ROM contents: a few known words, the rest a simple hash of the address.
  function automatic logic [31:0] rom_word(input logic [9:0] a);
    case (a)
      10'h024: return 32'h00000093;
      10'h020: return 32'h0100006F;
      10'h045: return 32'h11010000;
      default: return (32'h9E3779B1 * {22'b0, a}) + 32'h00001234;
    endcase
  endfunction

  // Single-port ROM macro: address latched when CSN low, Q valid next cycle.
  logic [9:0] rom_lat = '0;
  always @(posedge CLK) if (!rom_csn) rom_lat <= rom_a;
  assign rom_q = rom_word(rom_lat);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model state: who won last, and the response owed next cycle.
  bit          m_last_data;
  bit          p_instr, p_data, p_err;
  logic [31:0] p_rdata;

  function automatic bit instr_beats_data();
`ifdef BOOT_ROM_ARB_RR_EN
    return m_last_data;
`else
    return 1'b1;
`endif
  endfunction

  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge CLK); #1;
      RST = 1'b1; instr_req = 1'b1; data_req = 1'b1;
      instr_addr = 10'h010; data_addr = 10'h020;
      @(negedge CLK);
      chk("rst_instr_gnt", instr_gnt, 0);
      chk("rst_data_gnt", data_gnt, 0);
      chk("rst_csn", rom_csn, 1);
      chk("rst_a", rom_a, 0);
      chk("rst_instr_rvalid", instr_rvalid, 0);
      chk("rst_data_rvalid", data_rvalid, 0);
    end
    p_instr = 0; p_data = 0; p_err = 0; p_rdata = '0; m_last_data = 1;
  endtask

  task automatic cycle(input bit ri, input logic [9:0] ai, input bit rd, input logic [9:0] ad,
                       output bit gi, output bit gd);
    logic [9:0] ga;
    bit any, inr;
    @(posedge CLK); #1;
    RST = 1'b0; instr_req = ri; instr_addr = ai; data_req = rd; data_addr = ad;
    gi  = ri && (!rd || instr_beats_data());
    gd  = rd && !gi;
    any = gi || gd;
    ga  = gi ? ai : ad;
    inr = any && (int'(ga) < 548);
    @(negedge CLK);
    chk("instr_gnt", instr_gnt, gi);
    chk("data_gnt", data_gnt, gd);
    chk("rom_csn", rom_csn, !inr);
    if (inr || !any) chk("rom_a", rom_a, inr ? ga : 10'd0);
    chk("instr_rvalid", instr_rvalid, p_instr);
    chk("data_rvalid", data_rvalid, p_data);
    chk("instr_err", instr_err, p_instr && p_err);
    chk("data_err", data_err, p_data && p_err);
    chk("instr_rdata", instr_rdata, p_instr ? p_rdata : 32'd0);
    chk("data_rdata", data_rdata, p_data ? p_rdata : 32'd0);
    p_instr = gi; p_data = gd;
    p_err   = any && !inr;
    p_rdata = inr ? rom_word(ga) : 32'd0;
    if (gi) m_last_data = 0;
    else if (gd) m_last_data = 1;
  endtask

  typedef struct {
    bit ri; logic [9:0] ai; bit rd; logic [9:0] ad;
    bit gi; bit gd; bit csn; logic [9:0] a;
    bit port; bit err; logic [31:0] rdata;
  } vec_t;

  function automatic logic [9:0] rand_addr();
    case ($urandom_range(0, 5))
      0: return 10'd547;
      1: return 10'd548;
      2: return 10'($urandom_range(549, 1023));
      default: return 10'($urandom_range(0, 547));
    endcase
  endfunction

  initial begin
    vec_t tbl[6];
    bit gi, gd, ri, rd;
    logic [9:0] ai, ad;
    int n;

    tbl[0] = '{1, 10'h024, 0, 10'h000, 1, 0, 0, 10'h024, 0, 0, 32'h00000093};
    tbl[1] = '{0, 10'h000, 1, 10'd548,  0, 1, 1, 10'h000, 1, 1, 32'h00000000};
    tbl[2] = '{0, 10'h000, 1, 10'd547,  0, 1, 0, 10'd547, 1, 0, rom_word(10'd547)};
    tbl[3] = '{1, 10'd548, 0, 10'h000, 1, 0, 1, 10'h000, 0, 1, 32'h00000000};
    tbl[4] = '{0, 10'h000, 1, 10'h045, 0, 1, 0, 10'h045, 1, 0, 32'h11010000};
    tbl[5] = '{1, 10'd1023, 0, 10'h000, 1, 0, 1, 10'h000, 0, 1, 32'h00000000};

    // Reset held three cycles with both ports requesting.
    do_reset(3);
    @(posedge CLK); #1;
    RST = 0; instr_req = 0; data_req = 0;
    @(negedge CLK);
    chk("post_rst_instr_rvalid", instr_rvalid, 0);
    chk("post_rst_data_rvalid", data_rvalid, 0);
    chk("post_rst_instr_err", instr_err, 0);
    chk("post_rst_data_err", data_err, 0);

    // Table of single-port accesses including the range boundary.
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK); #1;
      instr_req = tbl[i].ri; instr_addr = tbl[i].ai;
      data_req = tbl[i].rd; data_addr = tbl[i].ad;
      @(negedge CLK);
      chk("tbl_instr_gnt", instr_gnt, tbl[i].gi);
      chk("tbl_data_gnt", data_gnt, tbl[i].gd);
      chk("tbl_csn", rom_csn, tbl[i].csn);
      if (!tbl[i].csn) chk("tbl_a", rom_a, tbl[i].a);
      @(posedge CLK); #1;
      instr_req = 0; data_req = 0;
      @(negedge CLK);
      chk("tbl_instr_rvalid", instr_rvalid, !tbl[i].port);
      chk("tbl_data_rvalid", data_rvalid, tbl[i].port);
      chk("tbl_err", tbl[i].port ? data_err : instr_err, tbl[i].err);
      chk("tbl_rdata", tbl[i].port ? data_rdata : instr_rdata, tbl[i].rdata);
      chk("tbl_idle_rdata", tbl[i].port ? instr_rdata : data_rdata, 0);
    end

    // Contention: both ports request continuously, then instr drops out.
    do_reset(2);
    for (int i = 0; i < 5; i++) cycle(1, 10'h020, 1, 10'h045, gi, gd);
    n = 0;
    gd = 0;
    while (!gd && n < 4) begin
      cycle(0, 10'h000, 1, 10'h045, gi, gd);
      n++;
    end
    chk("data_served_after_instr_drop", gd, 1);
    cycle(0, 10'h000, 0, 10'h000, gi, gd);

    // Reset in the cycle after a grant drops the response.
    cycle(1, 10'h040, 0, 10'h000, gi, gd);
    chk("rst_mid_gnt", gi, 1);
    do_reset(1);
    cycle(0, 10'h000, 0, 10'h000, gi, gd);
    cycle(0, 10'h000, 0, 10'h000, gi, gd);

    // Randomised traffic; ungranted requests are held stable until granted.
    ri = 0; rd = 0; ai = '0; ad = '0; gi = 1; gd = 1;
    for (int c = 0; c < 400; c++) begin
      if (!ri || gi) begin ri = bit'($urandom_range(0, 1)); ai = rand_addr(); end
      if (!rd || gd) begin rd = bit'($urandom_range(0, 1)); ad = rand_addr(); end
      if ($urandom_range(0, 59) == 0) begin
        do_reset(1);
        ri = 0; rd = 0; gi = 1; gd = 1;
      end else begin
        cycle(ri, ai, rd, ad, gi, gd);
      end
    end
    cycle(0, 10'h000, 0, 10'h000, gi, gd);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
